mem_stage_ctrl: RTL and testbench



---
 rtl/mem_stage_ctrl_pkg.sv | 27 ++
 rtl/mem_timeout_counter.sv | 43 ++++
 rtl/mem_stage_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: EX/M control bit positions,
// FSM state encoding and the default watchdog limit.
package mem_stage_ctrl_pkg;

  localparam int CTL_MEM_READ  = 0;
  localparam int CTL_MEM_WRITE = 1;
  localparam int CTL_REG_WRITE = 2;
  localparam int CTL_BRANCH    = 3;

  localparam logic [7:0] TIMEOUT_CYCLES_DEF = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_mem_op(input logic [3:0] ctl);
    return ctl[CTL_MEM_READ] | ctl[CTL_MEM_WRITE];
  endfunction

  // A request with both access bits set is treated as a store.
  function automatic logic is_load(input logic [3:0] ctl);
    return ctl[CTL_MEM_READ] & ~ctl[CTL_MEM_WRITE];
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Watchdog for an outstanding data-memory access; only built when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_counter
  import mem_stage_ctrl_pkg::*;
#(
  parameter logic [7:0] LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  output logic expired
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Cleared as the access is launched, then counts every cycle spent waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = 8'd0;
    end else if (active) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the LIMIT-th waiting cycle, i.e. the cycle whose increment reaches LIMIT.
  assign expired = active && ((cnt_q + 8'd1) == LIMIT);

endmodule
`endif

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: single-outstanding loads/stores, pipeline stall and M/WB strobe.
// Defining MEM_TIMEOUT_EN adds the access watchdog and the sticky mem_error output.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic [31:0] next_pc_in,
  input  logic        ALU_zero_in,
  input  logic [31:0] data_in,
  input  logic [3:0]  control_in,
  input  logic [4:0]  rgD_index_in,
  output logic        ex_m_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mwb_write,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rgD_index,
  output logic        wb_reg_write,
  output logic        branch_taken,
  output logic [31:0] branch_target
`ifdef MEM_TIMEOUT_EN
  ,
  output logic        mem_error
`endif
);

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  ctl_q, ctl_d;
  logic [4:0]  rgd_q, rgd_d;
  logic [31:0] result_q, result_d;
  logic        timed_out_q, timed_out_d;
  logic        timeout_hit_s;

`ifdef MEM_TIMEOUT_EN
  logic mem_error_q, mem_error_d;
  logic start_s;

  assign start_s = (state_q == ST_IDLE) && is_mem_op(control_in);

  mem_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .start   (start_s),
    .active  (state_q == ST_REQ),
    .expired (timeout_hit_s)
  );

  // An ack arriving in the expiry cycle takes precedence, so no error is flagged then.
  always_comb begin
    if ((state_q == ST_REQ) && !mem_ack && timeout_hit_s) begin
      mem_error_d = 1'b1;
    end else begin
      mem_error_d = mem_error_q;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_error_q <= 1'b0;
    end else begin
      mem_error_q <= mem_error_d;
    end
  end

  assign mem_error = mem_error_q;
`else
  logic unused_cfg;
  assign timeout_hit_s = 1'b0;
  assign unused_cfg    = |TIMEOUT_CYCLES;
`endif

  // Next-state, holding-register updates and stage outputs.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ctl_d        = ctl_q;
    rgd_d        = rgd_q;
    result_d     = result_q;
    timed_out_d  = timed_out_q;
    ex_m_write   = 1'b1;
    mwb_write    = 1'b0;
    wb_data      = 32'd0;
    wb_rgD_index = 5'd0;
    wb_reg_write = 1'b0;
    branch_taken = 1'b0;

    case (state_q)
      ST_IDLE: begin
        branch_taken = control_in[CTL_BRANCH] & ALU_zero_in;
        wb_data      = address_in;
        wb_rgD_index = rgD_index_in;
        if (is_mem_op(control_in)) begin
          ex_m_write  = 1'b0;
          addr_d      = address_in;
          wdata_d     = data_in;
          ctl_d       = control_in;
          rgd_d       = rgD_index_in;
          timed_out_d = 1'b0;
          mem_req_d   = 1'b1;
          state_d     = ST_REQ;
        end else begin
          mwb_write    = 1'b1;
          wb_reg_write = control_in[CTL_REG_WRITE];
        end
      end

      ST_REQ: begin
        ex_m_write = 1'b0;
        if (mem_ack) begin
          if (is_load(ctl_q)) begin
            result_d = mem_rdata;
          end else begin
            result_d = result_q;
          end
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
        end else if (timeout_hit_s) begin
          timed_out_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_DONE: begin
        mwb_write    = 1'b1;
        wb_rgD_index = rgd_q;
        if (timed_out_q) begin
          wb_data      = 32'd0;
          wb_reg_write = 1'b0;
        end else begin
          wb_reg_write = ctl_q[CTL_REG_WRITE];
          if (is_load(ctl_q)) begin
            wb_data = result_q;
          end else begin
            wb_data = addr_q;
          end
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and holding registers; reset drops mem_req at once, abandoning any access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      ctl_q       <= 4'd0;
      rgd_q       <= 5'd0;
      result_q    <= 32'd0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ctl_q       <= ctl_d;
      rgd_q       <= rgd_d;
      result_q    <= result_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = ctl_q[CTL_MEM_WRITE];
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign branch_target = next_pc_in;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: driver pushes expected write-back and memory
// requests, a responder and a monitor pop and compare. Covers MEM_TIMEOUT_EN when defined.
module tb_mem_stage_ctrl;

  localparam logic [7:0] TO_LIMIT = 8'd4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int NO_ACK = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_in = 32'd0;
  logic [31:0] next_pc_in = 32'd0;
  logic        ALU_zero_in = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic [3:0]  control_in = 4'd0;
  logic [4:0]  rgD_index_in = 5'd0;
  logic        ex_m_write;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mwb_write;
  logic [31:0] wb_data;
  logic [4:0]  wb_rgD_index;
  logic        wb_reg_write;
  logic        branch_taken;
  logic [31:0] branch_target;
`ifdef MEM_TIMEOUT_EN
  logic        mem_error;
`endif

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .TIMEOUT_CYCLES (TO_LIMIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .address_in    (address_in),
    .next_pc_in    (next_pc_in),
    .ALU_zero_in   (ALU_zero_in),
    .data_in       (data_in),
    .control_in    (control_in),
    .rgD_index_in  (rgD_index_in),
    .ex_m_write    (ex_m_write),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .mwb_write     (mwb_write),
    .wb_data       (wb_data),
    .wb_rgD_index  (wb_rgD_index),
    .wb_reg_write  (wb_reg_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
`ifdef MEM_TIMEOUT_EN
    ,
    .mem_error     (mem_error)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rgd;
    logic        rw;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
  } req_exp_t;

  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: every M/WB strobe must match the oldest expected write-back.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && mwb_write) begin
        chk("wb_expected_present", 32'(wb_q.size() != 0), 32'd1);
        if (wb_q.size() != 0) begin
          e = wb_q.pop_front();
          chk("wb_data", wb_data, e.data);
          chk("wb_rgd", 32'(wb_rgD_index), 32'(e.rgd));
          chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
        end
      end
    end
  end

  // Memory responder: checks request fields every REQ cycle and acks after the chosen delay.
  initial begin
    bit       busy = 1'b0;
    int       cnt = 0;
    req_exp_t r;
    r.addr = 32'd0; r.we = 1'b0; r.wdata = 32'd0; r.delay = NO_ACK; r.rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req && !reset) begin
        if (!busy) begin
          chk("req_expected_present", 32'(req_q.size() != 0), 32'd1);
          if (req_q.size() != 0) r = req_q.pop_front();
          busy = 1'b1;
          cnt  = 0;
        end
        chk("mem_addr", mem_addr, r.addr);
        chk("mem_we", 32'(mem_we), 32'(r.we));
        chk("mem_wdata", mem_wdata, r.wdata);
        if (cnt == r.delay) begin
          mem_ack   = 1'b1;
          mem_rdata = r.rdata;
          busy      = 1'b0;
        end
        cnt++;
      end else begin
        busy    = 1'b0;
        mem_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  // Present one EX/M entry, hold it while stalled, and check stall length and branch outputs.
  task automatic do_op(input logic [3:0] ctl, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] npc, input logic [4:0] rgd, input logic zero,
                       input int delay, input logic [31:0] rdata);
    int       stalls = 0;
    int       exp_stalls;
    bit       is_mem;
    bit       tout;
    wb_exp_t  w;
    req_exp_t r;
    control_in   = ctl;
    address_in   = addr;
    data_in      = data;
    next_pc_in   = npc;
    rgD_index_in = rgd;
    ALU_zero_in  = zero;
    is_mem = ctl[0] | ctl[1];
    tout   = is_mem && TO_EN && (delay >= int'(TO_LIMIT));
    w.rgd  = rgd;
    w.rw   = tout ? 1'b0 : ctl[2];
    if (tout) w.data = 32'd0;
    else if (is_mem && !ctl[1]) w.data = rdata;
    else w.data = addr;
    if (!is_mem) exp_stalls = 0;
    else if (tout) exp_stalls = int'(TO_LIMIT) + 1;
    else exp_stalls = delay + 2;
    wb_q.push_back(w);
    if (is_mem) begin
      r.addr = addr; r.we = ctl[1]; r.wdata = data; r.delay = delay; r.rdata = rdata;
      req_q.push_back(r);
    end
    @(negedge clk);
    chk("branch_taken", 32'(branch_taken), 32'(ctl[3] & zero));
    chk("branch_target", branch_target, npc);
    while (!ex_m_write && stalls < 400) begin
      stalls++;
      @(negedge clk);
      chk("branch_while_busy", 32'(branch_taken), 32'd0);
    end
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1);
  end

  initial begin
    req_exp_t r;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_ex_m_write", 32'(ex_m_write), 32'd1);
    chk("rst_mwb_write", 32'(mwb_write), 32'd1);
`ifdef MEM_TIMEOUT_EN
    chk("rst_mem_error", 32'(mem_error), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;

    do_op(4'b0100, 32'h0000_0010, 32'd0, 32'd0, 5'd5, 1'b0, 0, 32'd0);
    do_op(4'b0101, 32'h0000_0100, 32'h5555_0000, 32'd0, 5'd7, 1'b0, 2, 32'hDEAD_BEEF);
    do_op(4'b0010, 32'h0000_0200, 32'h0000_1234, 32'd0, 5'd3, 1'b0, 0, 32'd0);
    do_op(4'b1000, 32'h0000_0008, 32'd0, 32'h0000_0040, 5'd0, 1'b1, 0, 32'd0);
    do_op(4'b1000, 32'h0000_0008, 32'd0, 32'h0000_0040, 5'd0, 1'b0, 0, 32'd0);
    do_op(4'b0111, 32'h0000_0300, 32'hA5A5_A5A5, 32'd0, 5'd9, 1'b0, 1, 32'h1111_2222);
    do_op(4'b0000, 32'h0000_0ABC, 32'd0, 32'd0, 5'd0, 1'b0, 0, 32'd0);
    do_op(4'b0101, 32'h0000_0104, 32'd0, 32'd0, 5'd10, 1'b0, 0, 32'h0BAD_F00D);
    do_op(4'b0101, 32'h0000_0108, 32'd0, 32'd0, 5'd11, 1'b0, 3, 32'h7777_8888);

`ifdef MEM_TIMEOUT_EN
    do_op(4'b0101, 32'h0000_0500, 32'd0, 32'd0, 5'd12, 1'b0, NO_ACK, 32'hCAFE_0000);
    chk("timeout_mem_error", 32'(mem_error), 32'd1);
    do_op(4'b0100, 32'h0000_0600, 32'd0, 32'd0, 5'd13, 1'b0, 0, 32'd0);
`endif

    for (int i = 0; i < 300; i++) begin
      do_op(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom);
    end

    control_in   = 4'b0101;
    address_in   = 32'h0000_0700;
    data_in      = 32'h0000_0077;
    rgD_index_in = 5'd14;
    r.addr = 32'h0000_0700; r.we = 1'b0; r.wdata = 32'h0000_0077; r.delay = NO_ACK; r.rdata = 32'd0;
    req_q.push_back(r);
    @(posedge clk);
    #1;
    chk("mem_req_in_req", 32'(mem_req), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mem_req_on_reset", 32'(mem_req), 32'd0);
    control_in = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
`ifdef MEM_TIMEOUT_EN
    chk("mem_error_after_reset", 32'(mem_error), 32'd0);
`endif
    do_op(4'b0100, 32'h0000_0055, 32'd0, 32'd0, 5'd21, 1'b0, 0, 32'd0);
    do_op(4'b0001, 32'h0000_0800, 32'd0, 32'd0, 5'd22, 1'b0, 1, 32'h1357_9BDF);

    chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    chk("req_queue_drained", 32'(req_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
